// File: rtl/ika2151_reg_write_sched.sv
// Register-write scheduler: latches CPU address/data writes and commits each
// one as a strobe, global registers at once, per-slot registers when the
// operator pipeline reaches the target slot.
// Ports: i_EMUCLK/i_RST clock and sync reset, i_phi1_NCEN_n active-low enable,
//   i_CYCLE_31 slot-31 marker, i_AWR/i_DWR/i_DIN CPU writes; o_BUSY, o_SYNCED,
//   o_DROP status, o_WR_STB/GLB/ADDR/DATA/SLOT commit bundle.
module ika2151_reg_write_sched (
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic       i_AWR,
  input  logic       i_DWR,
  input  logic [7:0] i_DIN,
  output logic       o_BUSY,
  output logic       o_SYNCED,
  output logic       o_DROP,
  output logic       o_WR_STB,
  output logic       o_WR_GLB,
  output logic [7:0] o_WR_ADDR,
  output logic [7:0] o_WR_DATA,
  output logic [4:0] o_WR_SLOT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT
  } state_e;

  state_e     state_q;
  logic       awr_q, dwr_q;
  logic       synced_q, drop_q;
  logic       stb_q, busy_q, glb_q;
  logic [7:0] areg_q, addr_q, data_q;
  logic [4:0] scnt_q, slot_q;

  logic       en;
  logic       awr_rise, dwr_rise;
  logic [7:0] areg_d;
  logic       glb_d;
  logic [4:0] slot_d;
  logic [4:0] scnt_d;
  logic       match;

  always_comb begin
    en       = ~i_phi1_NCEN_n;
    awr_rise = i_AWR & ~awr_q;
    dwr_rise = i_DWR & ~dwr_q;
    // a same-enable address write feeds the data capture directly
    areg_d   = awr_rise ? i_DIN : areg_q;
    glb_d    = (areg_d[7:5] == 3'b000);
    slot_d   = 5'd0;
    unique case (1'b1)
      glb_d:                    slot_d = 5'd0;
      (areg_d[7:5] == 3'b001):  slot_d = {2'b00, areg_d[2:0]};
      default:                  slot_d = areg_d[4:0];
    endcase
    scnt_d   = i_CYCLE_31 ? 5'd0 : scnt_q + 5'd1;
    match    = synced_q && (scnt_q == slot_q);
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state_q  <= S_IDLE;
      awr_q    <= 1'b0;
      dwr_q    <= 1'b0;
      synced_q <= 1'b0;
      drop_q   <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      glb_q    <= 1'b0;
      areg_q   <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      scnt_q   <= 5'd0;
      slot_q   <= 5'd0;
    end else if (en) begin
      awr_q  <= i_AWR;
      dwr_q  <= i_DWR;
      areg_q <= areg_d;
      scnt_q <= scnt_d;
      if (i_CYCLE_31) synced_q <= 1'b1;
      drop_q <= dwr_rise && (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          if (dwr_rise) begin
            addr_q  <= areg_d;
            data_q  <= i_DIN;
            glb_q   <= glb_d;
            slot_q  <= slot_d;
            busy_q  <= 1'b1;
            stb_q   <= glb_d;
            state_q <= glb_d ? S_COMMIT : S_WAIT;
          end
        end
        S_WAIT: begin
          if (match) begin
            stb_q   <= 1'b1;
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_BUSY    = busy_q;
  assign o_SYNCED  = synced_q;
  assign o_DROP    = drop_q;
  assign o_WR_STB  = stb_q;
  assign o_WR_GLB  = glb_q;
  assign o_WR_ADDR = addr_q;
  assign o_WR_DATA = data_q;
  assign o_WR_SLOT = slot_q;

endmodule

// File: tb/tb_ika2151_reg_write_sched.sv
// Bench for ika2151_reg_write_sched: directed writes, per-edge model compare,
// and literal checks on commit timing and contents.
module tb_ika2151_reg_write_sched;

  logic       clk;
  logic       rst;
  logic       ncen;
  logic       cyc31;
  logic       awr;
  logic       dwr;
  logic [7:0] din;
  logic       o_BUSY, o_SYNCED, o_DROP, o_WR_STB, o_WR_GLB;
  logic [7:0] o_WR_ADDR, o_WR_DATA;
  logic [4:0] o_WR_SLOT;

  ika2151_reg_write_sched dut (
    .i_EMUCLK      (clk),
    .i_RST         (rst),
    .i_phi1_NCEN_n (ncen),
    .i_CYCLE_31    (cyc31),
    .i_AWR         (awr),
    .i_DWR         (dwr),
    .i_DIN         (din),
    .o_BUSY        (o_BUSY),
    .o_SYNCED      (o_SYNCED),
    .o_DROP        (o_DROP),
    .o_WR_STB      (o_WR_STB),
    .o_WR_GLB      (o_WR_GLB),
    .o_WR_ADDR     (o_WR_ADDR),
    .o_WR_DATA     (o_WR_DATA),
    .o_WR_SLOT     (o_WR_SLOT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_stb = 0;
  logic prev_stb = 1'b0;
  bit gate = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model state, described in terms of the pending write and its commit
  logic       m_pawr, m_pdwr, m_sync, m_pend, m_commit, m_drop, m_glb;
  logic [7:0] m_areg, m_addr, m_data;
  logic [4:0] m_scnt, m_slot;
  logic       aw_r, dw_r, busy_before, commit_before;
  logic [7:0] na;

  function automatic logic [25:0] dut_vec();
    return {o_BUSY, o_SYNCED, o_DROP, o_WR_STB, o_WR_GLB,
            o_WR_ADDR, o_WR_DATA, o_WR_SLOT};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pawr = 0; m_pdwr = 0; m_sync = 0; m_pend = 0; m_commit = 0;
      m_drop = 0; m_glb = 0; m_areg = 0; m_addr = 0; m_data = 0;
      m_scnt = 0; m_slot = 0;
    end else if (!ncen) begin
      aw_r = awr && !m_pawr;
      dw_r = dwr && !m_pdwr;
      m_pawr = awr;
      m_pdwr = dwr;
      na = aw_r ? din : m_areg;
      busy_before = m_pend;
      commit_before = m_commit;
      m_drop = dw_r && busy_before;
      if (commit_before) begin
        m_pend = 0;
        m_commit = 0;
      end else if (m_pend) begin
        if (m_sync && m_scnt == m_slot) m_commit = 1;
      end else if (dw_r) begin
        m_pend = 1;
        m_addr = na;
        m_data = din;
        if (na < 8'h20) begin
          m_glb = 1; m_slot = 0; m_commit = 1;
        end else if (na < 8'h40) begin
          m_glb = 0; m_slot = 5'(na % 8);
        end else begin
          m_glb = 0; m_slot = 5'(na % 32);
        end
      end
      m_areg = na;
      if (cyc31) begin
        m_scnt = 0;
        m_sync = 1;
      end else begin
        m_scnt = m_scnt + 5'd1;
      end
    end
    #1;
    chk("cycle", 32'(dut_vec()),
        32'({m_pend, m_sync, m_drop, m_commit, m_glb,
             m_addr, m_data, m_slot}));
    if (o_WR_STB && !prev_stb) n_stb++;
    prev_stb = o_WR_STB;
  end

  task automatic en(input int n);
    repeat (n) begin
      if (gate) begin
        ncen = 1'b1;
        @(negedge clk);
      end
      ncen = 1'b0;
      @(negedge clk);
      ncen = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ncen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_stb(input int max, output int waited);
    waited = 0;
    while (!o_WR_STB && waited < max) begin
      en(1);
      waited++;
    end
    if (!o_WR_STB) chk("stb_timeout", 32'(o_WR_STB), 32'd1);
  endtask

  int w;
  int base;

  initial begin
    rst = 1'b1; ncen = 1'b1; cyc31 = 1'b0;
    awr = 1'b0; dwr = 1'b0; din = 8'h00;
    @(negedge clk);
    do_reset();
    chk("reset_outs", 32'(dut_vec()), 32'd0);

    // global write
    din = 8'h08; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'h5A; dwr = 1'b1; en(1);
    chk("glb_stb", 32'({o_WR_STB, o_BUSY, o_WR_GLB}), 32'b111);
    chk("glb_addr", 32'(o_WR_ADDR), 32'h08);
    chk("glb_data", 32'(o_WR_DATA), 32'h5A);
    chk("glb_slot", 32'(o_WR_SLOT), 32'd0);
    dwr = 1'b0; en(1);
    chk("glb_after", 32'({o_WR_STB, o_BUSY}), 32'b00);

    // operator write after sync, with disabled edges interleaved
    gate = 1;
    cyc31 = 1'b1; en(1);
    cyc31 = 1'b0;
    chk("synced", 32'(o_SYNCED), 32'd1);
    din = 8'h73; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'h11; dwr = 1'b1; en(1);
    dwr = 1'b0;
    wait_stb(40, w);
    chk("op_wait", 32'(w), 32'd17);
    chk("op_slot", 32'({o_WR_GLB, o_WR_SLOT}), 32'd19);
    en(1);
    chk("op_busy_off", 32'(o_BUSY), 32'd0);
    gate = 0;

    // channel write while unsynced
    do_reset();
    din = 8'h2E; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'hC0; dwr = 1'b1; en(1);
    dwr = 1'b0;
    base = n_stb;
    en(10);
    chk("ch_held", 32'({o_BUSY, o_WR_STB}), 32'b10);
    chk("ch_nostb", 32'(n_stb - base), 32'd0);
    cyc31 = 1'b1; en(1);
    cyc31 = 1'b0;
    wait_stb(40, w);
    chk("ch_wait", 32'(w), 32'd7);
    chk("ch_bundle", 32'({o_WR_SLOT, o_WR_ADDR, o_WR_DATA}),
        32'({5'd6, 8'h2E, 8'hC0}));
    en(1);

    // busy collisions
    din = 8'h50; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'h33; dwr = 1'b1; en(1);
    dwr = 1'b0;
    din = 8'h40; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'hFF; dwr = 1'b1; en(1);
    chk("drop_hi", 32'(o_DROP), 32'd1);
    dwr = 1'b0; en(1);
    chk("drop_lo", 32'(o_DROP), 32'd0);
    wait_stb(40, w);
    chk("col_keep", 32'({o_WR_ADDR, o_WR_DATA}), 32'h5033);
    en(1);
    din = 8'h77; dwr = 1'b1; en(1);
    dwr = 1'b0;
    wait_stb(40, w);
    chk("col_areg", 32'({o_WR_ADDR, o_WR_DATA, 3'b0, o_WR_SLOT}),
        32'h407700);
    en(1);

    // held level and simultaneous AWR/DWR
    din = 8'h1F; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'h10; dwr = 1'b1;
    base = n_stb;
    en(40);
    chk("held_once", 32'(n_stb - base), 32'd1);
    dwr = 1'b0; en(1);
    din = 8'h05; awr = 1'b1; dwr = 1'b1; en(1);
    chk("simul", 32'({o_WR_STB, o_WR_GLB, o_WR_ADDR, o_WR_DATA}),
        32'({2'b11, 8'h05, 8'h05}));
    awr = 1'b0; dwr = 1'b0; en(1);

    // reset while waiting for slot 31
    din = 8'h7F; awr = 1'b1; en(1);
    awr = 1'b0; en(1);
    din = 8'hAB; dwr = 1'b1; cyc31 = 1'b1; en(1);
    dwr = 1'b0; cyc31 = 1'b0;
    en(3);
    chk("rst_wait_busy", 32'({o_BUSY, o_WR_STB}), 32'b10);
    base = n_stb;
    do_reset();
    chk("rst_mid_outs", 32'(dut_vec()), 32'd0);
    en(40);
    chk("rst_nostb", 32'(n_stb - base), 32'd0);
    chk("rst_unsync", 32'({o_SYNCED, o_BUSY}), 32'b00);
    cyc31 = 1'b1; en(1);
    cyc31 = 1'b0;
    chk("resync", 32'(o_SYNCED), 32'd1);
    en(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
